// File: rtl/prf_free_list_ctrl_if.sv
// rtl/prf_free_list_ctrl_if.sv - rename/retire/flush bundle for the physical register free list
//
// Purpose: groups every free-list signal except clk/reset.
// master : rename/retire side (drives flush, alloc_req, retire, retire_free_tag)
// slave  : free list (drives alloc_gnt, alloc_tag, free_count, stall, err)
//   flush            1                 mispredict recovery
//   alloc_req        SCALAR            per-way tag request
//   alloc_gnt        SCALAR            per-way grant
//   alloc_tag        SCALAR*PRF_IDX    per-way tag, way0 in the low slice
//   retire           SCALAR            per-way retire
//   retire_free_tag  SCALAR*PRF_IDX    previous mapping to free per retiring way
//   free_count       PRF_IDX+1         speculatively free tag count
//   stall            1                 some request was not granted
//   err              1                 sticky protocol error
interface prf_free_list_ctrl_if #(
    parameter int SCALAR  = 2,
    parameter int PRF_IDX = 6
);
    logic                        flush;
    logic [SCALAR-1:0]           alloc_req;
    logic [SCALAR-1:0]           alloc_gnt;
    logic [SCALAR*PRF_IDX-1:0]   alloc_tag;
    logic [SCALAR-1:0]           retire;
    logic [SCALAR*PRF_IDX-1:0]   retire_free_tag;
    logic [PRF_IDX:0]            free_count;
    logic                        stall;
    logic                        err;

    modport master (
        output flush, alloc_req, retire, retire_free_tag,
        input  alloc_gnt, alloc_tag, free_count, stall, err
    );

    modport slave (
        input  flush, alloc_req, retire, retire_free_tag,
        output alloc_gnt, alloc_tag, free_count, stall, err
    );
endinterface

// File: rtl/prf_free_list_ctrl.sv
// rtl/prf_free_list_ctrl.sv - physical register free list with speculative and architectural heads
//
// Purpose: circular tag FIFO feeding a SCALAR-wide rename stage. The alloc head
// is speculative, the retire head is architectural, the tail takes freed tags.
// A flush snaps the alloc head back to the retire head.
// Ports:
//   clk    in  clock
//   reset  in  synchronous active-high reset
//   fl     slave modport of prf_free_list_ctrl_if (all handshake signals)
module prf_free_list_ctrl #(
    parameter int SCALAR   = 2,
    parameter int PRF_IDX  = 6,
    parameter int PRF_SZ   = 64,
    parameter int ZERO_PRF = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    prf_free_list_ctrl_if.slave     fl
);
    localparam int CW = PRF_IDX + 1;
    localparam logic [CW:0] MAX_ARCH = (CW+1)'(PRF_SZ - 1);

    logic [PRF_IDX-1:0] entries_q [PRF_SZ];
    logic [PRF_IDX-1:0] alloc_head_q, alloc_head_d;
    logic [PRF_IDX-1:0] retire_head_q, retire_head_d;
    logic [PRF_IDX-1:0] tail_q, tail_d;
    logic [CW-1:0]      free_count_q, free_count_d;
    logic [CW-1:0]      arch_count_q, arch_count_d;
    logic               err_q, err_d;

    logic [SCALAR-1:0]         gnt;
    logic [SCALAR*PRF_IDX-1:0] tags;
    logic [CW-1:0]             n_req, n_gnt, n_free, n_ret, outstanding;
    logic [CW:0]               arch_sum;
    logic [PRF_IDX-1:0]        rd_idx;
    logic [SCALAR-1:0]         wr_en;
    logic [PRF_IDX-1:0]        wr_idx [SCALAR];
    logic [PRF_IDX-1:0]        wr_tag [SCALAR];

    always_comb begin
        gnt    = '0;
        tags   = '0;
        n_req  = '0;
        n_gnt  = '0;
        rd_idx = '0;
        for (int i = 0; i < SCALAR; i++) begin
            // Threshold is the number of requests up to and including way i,
            // so a younger way can never be served while an older one starves.
            n_req  = n_req + CW'(fl.alloc_req[i]);
            rd_idx = alloc_head_q + n_gnt[PRF_IDX-1:0];
            tags[i*PRF_IDX +: PRF_IDX] = entries_q[rd_idx];
            if (fl.alloc_req[i] && !fl.flush && !reset && (free_count_q >= n_req)) begin
                gnt[i] = 1'b1;
                n_gnt  = n_gnt + CW'(1);
            end
        end
    end

    always_comb begin
        wr_en  = '0;
        n_free = '0;
        n_ret  = '0;
        for (int i = 0; i < SCALAR; i++) begin
            // Frees pack densely at the tail in way order; the zero tag is dropped.
            wr_idx[i] = tail_q + n_free[PRF_IDX-1:0];
            wr_tag[i] = fl.retire_free_tag[i*PRF_IDX +: PRF_IDX];
            n_ret     = n_ret + CW'(fl.retire[i]);
            if (fl.retire[i] && (wr_tag[i] != PRF_IDX'(ZERO_PRF))) begin
                wr_en[i] = 1'b1;
                n_free   = n_free + CW'(1);
            end
        end
    end

    always_comb begin
        // Tags handed out but not yet retired sit between the two heads.
        outstanding   = arch_count_q - free_count_q;
        arch_sum      = {1'b0, arch_count_q} + {1'b0, n_free} - {1'b0, n_ret};
        arch_count_d  = arch_sum[CW-1:0];
        err_d         = err_q | (n_ret > outstanding) | (arch_sum > MAX_ARCH);
        retire_head_d = retire_head_q + n_ret[PRF_IDX-1:0];
        tail_d        = tail_q + n_free[PRF_IDX-1:0];
        if (fl.flush) begin
            alloc_head_d = retire_head_d;
            free_count_d = arch_count_d;
        end else begin
            alloc_head_d = alloc_head_q + n_gnt[PRF_IDX-1:0];
            free_count_d = free_count_q - n_gnt + n_free;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < PRF_SZ; i++) begin
                entries_q[i] <= (i == PRF_SZ - 1) ? PRF_IDX'(ZERO_PRF) : PRF_IDX'(i + 1);
            end
            alloc_head_q  <= '0;
            retire_head_q <= '0;
            tail_q        <= PRF_IDX'(PRF_SZ - 1);
            free_count_q  <= CW'(PRF_SZ - 1);
            arch_count_q  <= CW'(PRF_SZ - 1);
            err_q         <= 1'b0;
        end else begin
            for (int i = 0; i < SCALAR; i++) begin
                if (wr_en[i]) begin
                    entries_q[wr_idx[i]] <= wr_tag[i];
                end
            end
            alloc_head_q  <= alloc_head_d;
            retire_head_q <= retire_head_d;
            tail_q        <= tail_d;
            free_count_q  <= free_count_d;
            arch_count_q  <= arch_count_d;
            err_q         <= err_d;
        end
    end

    assign fl.alloc_gnt  = gnt;
    assign fl.alloc_tag  = tags;
    assign fl.stall      = |(fl.alloc_req & ~gnt);
    assign fl.free_count = free_count_q;
    assign fl.err        = err_q;
endmodule

// File: tb/tb_prf_free_list_ctrl.sv
// tb/tb_prf_free_list_ctrl.sv - scoreboard bench for prf_free_list_ctrl
module tb_prf_free_list_ctrl;
    localparam int W = 6;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    prf_free_list_ctrl_if #(.SCALAR(2), .PRF_IDX(W)) bus ();

    prf_free_list_ctrl #(.SCALAR(2), .PRF_IDX(W), .PRF_SZ(64), .ZERO_PRF(0)) dut (
        .clk   (clk),
        .reset (reset),
        .fl    (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Model: free list as an ordered queue, in-flight tags as a second queue.
    int freeq[$];
    int infl[$];
    bit err_m;

    typedef struct { int fc; int err; } reg_exp_t;
    reg_exp_t sb[$];

    task automatic model_reset();
        freeq = {};
        infl  = {};
        for (int t = 1; t < 64; t++) freeq.push_back(t);
        err_m = 1'b0;
    endtask

    task automatic cyc(input logic [1:0] req, input logic [1:0] ret,
                       input int f0, input int f1, input bit fl);
        int sz;
        bit g0, g1;
        int nret;
        reg_exp_t e;
        @(negedge clk);
        reset               = 1'b0;
        bus.flush           = fl;
        bus.alloc_req       = req;
        bus.retire          = ret;
        bus.retire_free_tag = {W'(f1), W'(f0)};
        #1;
        sz = freeq.size();
        g0 = req[0] && !fl && (sz >= 1);
        g1 = req[1] && !fl && (sz >= (req[0] ? 2 : 1));
        check("gnt", bus.alloc_gnt, {g1, g0});
        check("stall", bus.stall, (req[0] && !g0) || (req[1] && !g1));
        if (sz > 0) check("tag0", bus.alloc_tag[W-1:0], freeq[0]);
        if (g1) check("tag1", bus.alloc_tag[2*W-1:W], freeq[g0]);
        check("free_count_now", bus.free_count, sz);
        check("err_now", bus.err, err_m);

        nret = int'(ret[0]) + int'(ret[1]);
        if (nret > infl.size()) err_m = 1'b1;
        for (int k = 0; k < nret; k++) if (infl.size() > 0) void'(infl.pop_front());
        if (g0) infl.push_back(freeq.pop_front());
        if (g1) infl.push_back(freeq.pop_front());
        if (ret[0] && f0 != 0) freeq.push_back(f0);
        if (ret[1] && f1 != 0) freeq.push_back(f1);
        if (infl.size() + freeq.size() > 63) err_m = 1'b1;
        if (fl) begin
            freeq = {infl, freeq};
            infl  = {};
        end
        e.fc  = freeq.size();
        e.err = err_m;
        sb.push_back(e);

        @(posedge clk);
        #1;
        e = sb.pop_front();
        check("free_count", bus.free_count, e.fc);
        check("err", bus.err, e.err);
    endtask

    task automatic do_reset();
        reg_exp_t e;
        @(negedge clk);
        reset               = 1'b1;
        bus.flush           = 1'($urandom);
        bus.alloc_req       = 2'($urandom);
        bus.retire          = 2'($urandom);
        bus.retire_free_tag = 12'($urandom);
        #1;
        check("gnt_in_reset", bus.alloc_gnt, 2'b00);
        model_reset();
        e.fc  = 63;
        e.err = 0;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check("reset_free_count", bus.free_count, e.fc);
        check("reset_err", bus.err, e.err);
    endtask

    initial begin
        logic [1:0] r;
        int nr, ft[2], k;
        reset               = 1'b1;
        bus.flush           = 1'b0;
        bus.alloc_req       = '0;
        bus.retire          = '0;
        bus.retire_free_tag = '0;
        model_reset();

        // Idle, 2-way grants up to exhaustion, then zero-tag free and reuse.
        do_reset();
        cyc(2'b00, 2'b00, 0, 0, 0);
        for (int i = 0; i < 31; i++) cyc(2'b11, 2'b00, 0, 0, 0);
        cyc(2'b11, 2'b00, 0, 0, 0);
        cyc(2'b01, 2'b00, 0, 0, 0);
        cyc(2'b00, 2'b11, 0, 5, 0);
        cyc(2'b01, 2'b00, 0, 0, 0);
        cyc(2'b11, 2'b00, 0, 0, 0);

        // Flush with nothing retired.
        do_reset();
        for (int i = 0; i < 5; i++) cyc(2'b11, 2'b00, 0, 0, 0);
        cyc(2'b11, 2'b00, 0, 0, 1);
        cyc(2'b00, 2'b00, 0, 0, 0);

        // Flush with same-cycle retire.
        do_reset();
        cyc(2'b11, 2'b00, 0, 0, 0);
        cyc(2'b11, 2'b00, 0, 0, 0);
        cyc(2'b00, 2'b11, 0, 0, 1);
        cyc(2'b00, 2'b00, 0, 0, 0);

        // Retire with nothing allocated; err is sticky until reset.
        do_reset();
        cyc(2'b00, 2'b01, 0, 0, 0);
        cyc(2'b00, 2'b00, 0, 0, 0);
        cyc(2'b00, 2'b00, 0, 0, 0);
        do_reset();
        cyc(2'b00, 2'b00, 0, 0, 0);

        // Random legal traffic: retires never exceed in-flight tags, frees reuse retiring tags.
        for (int i = 0; i < 300; i++) begin
            r  = 2'($urandom);
            nr = int'(r[0]) + int'(r[1]);
            while (nr > infl.size()) begin
                r  = 2'($urandom);
                nr = int'(r[0]) + int'(r[1]);
            end
            ft[0] = 0;
            ft[1] = 0;
            k = 0;
            for (int w = 0; w < 2; w++) begin
                if (r[w]) begin
                    ft[w] = ($urandom_range(0, 3) == 0) ? 0 : infl[k];
                    k++;
                end
            end
            cyc(2'($urandom), r, ft[0], ft[1], ($urandom_range(0, 15) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
